// File: rtl/wb_dma_mast_arb.sv
// Two-requester round-robin arbiter feeding a single WISHBONE master engine.
// Latches the winner's burst parameters and sequences beats until done, error or reset.
module wb_dma_mast_arb #(
   parameter int unsigned LEN_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [1:0]         req_we,
   input  logic [63:0]        req_adr,
   input  logic [2*LEN_W-1:0] req_len,
   input  logic [63:0]        req_wdata,
   input  logic [1:0]         req_wait,
   output logic [1:0]         gnt,
   output logic [1:0]         drdy,
   output logic [1:0]         done,
   output logic [1:0]         err,
   output logic [31:0]        rdata,
   output logic               mast_go,
   output logic               mast_we,
   output logic [31:0]        mast_adr,
   output logic [31:0]        mast_din,
   output logic               mast_wait,
   input  logic               mast_drdy,
   input  logic               mast_err,
   input  logic [31:0]        mast_dout
);

   typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             we_q, we_d;
   logic [31:0]      adr_q, adr_d;
   logic [LEN_W-1:0] len_q, len_d;
   // One extra bit so a full-length burst never wraps the beat count.
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic [1:0]       done_q, done_d;
   logic [1:0]       err_q, err_d;

   logic       xfer;
   logic       last_beat;
   logic [1:0] owner_oh;

   assign xfer      = (state_q == StXfer);
   assign last_beat = (cnt_q == {1'b0, len_q});
   assign owner_oh  = owner_q ? 2'b10 : 2'b01;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      adr_d   = adr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      done_d  = 2'b00;
      err_d   = 2'b00;
      case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               // With both requesting, the one not granted last time wins.
               owner_d = (req == 2'b11) ? ~last_q : req[1];
               last_d  = owner_d;
               we_d    = owner_d ? req_we[1] : req_we[0];
               adr_d   = owner_d ? req_adr[63:32] : req_adr[31:0];
               len_d   = owner_d ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
               cnt_d   = '0;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (mast_err) begin
               err_d   = owner_oh;
               state_d = StGap;
            end else if (mast_drdy) begin
               cnt_d = cnt_q + (LEN_W+1)'(1);
               if (last_beat) begin
                  done_d  = owner_oh;
                  state_d = StGap;
               end
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         adr_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      gnt       = xfer ? owner_oh : 2'b00;
      drdy      = (xfer && mast_drdy) ? owner_oh : 2'b00;
      done      = done_q;
      err       = err_q;
      rdata     = mast_dout;
      // Suppress the strobe in the final-ack cycle so no extra bus cycle starts.
      mast_go   = xfer && !mast_err && !(mast_drdy && last_beat);
      mast_we   = xfer && we_q;
      mast_adr  = adr_q + 32'({cnt_q, 2'b00});
      mast_din  = xfer ? (owner_q ? req_wdata[63:32] : req_wdata[31:0]) : 32'h0;
      mast_wait = xfer && (owner_q ? req_wait[1] : req_wait[0]);
   end

endmodule
